// File: rtl/cpu_mul_seq_ctrl.sv
// cpu_mul_seq_ctrl: sequencing and combine stage around the three-product
// 16x16 multiplier cell. It latches a 32x32 request and drives the cell for
// CELL_LATENCY enabled cycles. It then folds p1 + (p2 + p3) << 16 into the
// low 32 bits of the product and returns that over a valid/ready response.
module cpu_mul_seq_ctrl #(
  parameter int unsigned CELL_LATENCY = 1  // legal range 1..7
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] mul_src1,
  output logic [31:0] mul_src2,
  output logic        mul_en,
  input  logic [31:0] cell_p1,
  input  logic [31:0] cell_p2,
  input  logic [31:0] cell_p3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_COMBINE,
    S_RESP
  } state_t;

  localparam logic [2:0] LAT_M1 = 3'(CELL_LATENCY - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] src1_q, src1_d;
  logic [31:0] src2_q, src2_d;
  logic [31:0] result_q, result_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        accept;
  logic [31:0] combined;

  // Only the low 16 bits of the cross-term survive the shift; the cell
  // computes the 16x16 partials, so the high half product never appears.
  assign combined = cell_p1 + ((cell_p2 + cell_p3) << 16);

  // Ready in IDLE, or in RESP when the consumer drains the result this cycle
  // (a combinational rsp_ready -> req_ready path). Flush blocks acceptance.
  assign req_ready = ~flush & ((state_q == S_IDLE) |
                               ((state_q == S_RESP) & rsp_ready));
  assign accept    = req_ready & req_valid;

  assign mul_en     = (state_q == S_ISSUE);
  assign busy       = (state_q != S_IDLE);
  assign mul_src1   = src1_q;
  assign mul_src2   = src2_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = result_q;

  // Next-state and datapath load decisions; flush overrides everything last.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    src1_d      = src1_q;
    src2_d      = src2_q;
    result_d    = result_q;
    rsp_valid_d = rsp_valid_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          src1_d  = req_a;
          src2_d  = req_b;
          cnt_d   = LAT_M1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cnt_q == 3'd0) begin
          state_d = S_COMBINE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_COMBINE: begin
        result_d    = combined;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (accept) begin
            src1_d  = req_a;
            src2_d  = req_b;
            cnt_d   = LAT_M1;
            state_d = S_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort: operands and the last result are deliberately left in place.
    if (flush) begin
      state_d     = S_IDLE;
      cnt_d       = 3'd0;
      rsp_valid_d = 1'b0;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      src1_q      <= 32'd0;
      src2_q      <= 32'd0;
      result_q    <= 32'd0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      src1_q      <= src1_d;
      src2_q      <= src2_d;
      result_q    <= result_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

endmodule

// File: tb/tb_cpu_mul_seq_ctrl.sv
// Directed bench for cpu_mul_seq_ctrl: one instance at CELL_LATENCY=1 and one
// at CELL_LATENCY=3, each driving a behavioural model of the multiplier cell.
module tb_cpu_mul_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- instance with CELL_LATENCY = 1 ----------------
  logic        reset_n, flush1, req_valid1, req_ready1, mul_en1;
  logic        rsp_valid1, rsp_ready1, busy1;
  logic [31:0] req_a1, req_b1, src1_1, src2_1, rsp_result1;
  logic [31:0] p1_1 = 32'd0, p2_1 = 32'd0, p3_1 = 32'd0;

  cpu_mul_seq_ctrl #(.CELL_LATENCY(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .flush(flush1),
    .req_valid(req_valid1), .req_ready(req_ready1),
    .req_a(req_a1), .req_b(req_b1),
    .mul_src1(src1_1), .mul_src2(src2_1), .mul_en(mul_en1),
    .cell_p1(p1_1), .cell_p2(p2_1), .cell_p3(p3_1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
    .rsp_result(rsp_result1), .busy(busy1)
  );

  // ---------------- instance with CELL_LATENCY = 3 ----------------
  logic        rst3_n, flush3, req_valid3, req_ready3, mul_en3;
  logic        rsp_valid3, rsp_ready3, busy3;
  logic [31:0] req_a3, req_b3, src1_3, src2_3, rsp_result3;
  logic [31:0] s0_1 = 32'd0, s0_2 = 32'd0, s0_3 = 32'd0;
  logic [31:0] s1_1 = 32'd0, s1_2 = 32'd0, s1_3 = 32'd0;
  logic [31:0] p1_3 = 32'd0, p2_3 = 32'd0, p3_3 = 32'd0;

  cpu_mul_seq_ctrl #(.CELL_LATENCY(3)) dut3 (
    .clk(clk), .reset_n(rst3_n), .flush(flush3),
    .req_valid(req_valid3), .req_ready(req_ready3),
    .req_a(req_a3), .req_b(req_b3),
    .mul_src1(src1_3), .mul_src2(src2_3), .mul_en(mul_en3),
    .cell_p1(p1_3), .cell_p2(p2_3), .cell_p3(p3_3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
    .rsp_result(rsp_result3), .busy(busy3)
  );

  function automatic logic [31:0] pp(input logic [15:0] x, input logic [15:0] y);
    return 32'(x) * 32'(y);
  endfunction

  // Cell models: partial products advance only on enabled edges.
  always @(posedge clk) begin
    if (mul_en1) begin
      p1_1 <= pp(src1_1[15:0],  src2_1[15:0]);
      p2_1 <= pp(src1_1[15:0],  src2_1[31:16]);
      p3_1 <= pp(src1_1[31:16], src2_1[15:0]);
    end
    if (mul_en3) begin
      s0_1 <= pp(src1_3[15:0],  src2_3[15:0]);
      s0_2 <= pp(src1_3[15:0],  src2_3[31:16]);
      s0_3 <= pp(src1_3[31:16], src2_3[15:0]);
      s1_1 <= s0_1; s1_2 <= s0_2; s1_3 <= s0_3;
      p1_3 <= s1_1; p2_3 <= s1_2; p3_3 <= s1_3;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the latency-1 instance with rsp_ready held high.
  task automatic txn1(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp, input string tag);
    int cyc;
    int en;
    req_a1 = a; req_b1 = b; req_valid1 = 1'b1; rsp_ready1 = 1'b1;
    chk({tag, " req_ready"}, 32'(req_ready1), 32'd1);
    tick();
    req_valid1 = 1'b0;
    cyc = 0; en = 0;
    while (!rsp_valid1 && cyc < 20) begin
      if (mul_en1) en++;
      tick();
      cyc++;
    end
    chk({tag, " latency"}, 32'(cyc), 32'd2);
    chk({tag, " mul_en cycles"}, 32'(en), 32'd1);
    chk({tag, " result"}, rsp_result1, exp);
    tick();
    chk({tag, " idle after handshake"}, {30'd0, rsp_valid1, busy1}, 32'd0);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int cyc;
    int en;
    logic seen;

    vecs[0] = '{32'h0001_0003, 32'h0000_0005, 32'h0005_000F};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[2] = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0000};
    vecs[3] = '{32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE};
    vecs[4] = '{32'h0000_0100, 32'h0000_0100, 32'h0001_0000};
    vecs[5] = '{32'h8000_0000, 32'h0000_0003, 32'h8000_0000};

    reset_n = 1'b0; flush1 = 1'b0; req_valid1 = 1'b0; rsp_ready1 = 1'b0;
    req_a1 = 32'd0; req_b1 = 32'd0;
    rst3_n = 1'b0; flush3 = 1'b0; req_valid3 = 1'b0; rsp_ready3 = 1'b0;
    req_a3 = 32'd0; req_b3 = 32'd0;
    tick();
    tick();
    chk("reset ctrl bits", {29'd0, busy1, rsp_valid1, mul_en1}, 32'd0);
    chk("reset mul_src1", src1_1, 32'd0);
    chk("reset mul_src2", src2_1, 32'd0);
    chk("reset rsp_result", rsp_result1, 32'd0);
    reset_n = 1'b1; rst3_n = 1'b1;
    tick();
    chk("req_ready after reset", 32'(req_ready1), 32'd1);

    for (int i = 0; i < 6; i++) begin
      txn1(vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Response stalled for 5 cycles: output must hold and block requests.
    req_a1 = 32'd3; req_b1 = 32'd7; req_valid1 = 1'b1; rsp_ready1 = 1'b0;
    tick();
    req_valid1 = 1'b0;
    cyc = 0;
    while (!rsp_valid1 && cyc < 20) begin
      tick();
      cyc++;
    end
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall%0d rsp_valid", i), 32'(rsp_valid1), 32'd1);
      chk($sformatf("stall%0d result", i), rsp_result1, 32'h15);
      chk($sformatf("stall%0d req_ready", i), 32'(req_ready1), 32'd0);
      tick();
    end
    rsp_ready1 = 1'b1;
    tick();
    chk("stall released", 32'(rsp_valid1), 32'd0);

    // Back-to-back: second request accepted on the first response handshake.
    req_a1 = 32'd2; req_b1 = 32'd3; req_valid1 = 1'b1; rsp_ready1 = 1'b1;
    tick();
    req_a1 = 32'd4; req_b1 = 32'd5;
    chk("b2b req_ready in ISSUE", 32'(req_ready1), 32'd0);
    tick();
    tick();
    chk("b2b first valid", 32'(rsp_valid1), 32'd1);
    chk("b2b first result", rsp_result1, 32'h6);
    chk("b2b req_ready in RESP", 32'(req_ready1), 32'd1);
    tick();
    req_valid1 = 1'b0;
    chk("b2b second issue", {30'd0, rsp_valid1, mul_en1}, 32'd1);
    chk("b2b second operand", src1_1, 32'd4);
    tick();
    tick();
    chk("b2b second valid", 32'(rsp_valid1), 32'd1);
    chk("b2b second result", rsp_result1, 32'h14);
    tick();
    chk("b2b idle", 32'(busy1), 32'd0);

    // Flush during ISSUE with a concurrent request.
    req_a1 = 32'd5; req_b1 = 32'd5; req_valid1 = 1'b1;
    tick();
    flush1 = 1'b1; req_a1 = 32'h77; req_b1 = 32'd1;
    chk("flush req_ready", 32'(req_ready1), 32'd0);
    tick();
    flush1 = 1'b0; req_valid1 = 1'b0;
    chk("flush busy/valid", {30'd0, busy1, rsp_valid1}, 32'd0);
    chk("flush operand kept", src1_1, 32'd5);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid1) seen = 1'b1;
      tick();
    end
    chk("flush no response", 32'(seen), 32'd0);
    txn1(32'h10, 32'h10, 32'h100, "post-flush");

    // CELL_LATENCY = 3 instance.
    req_a3 = 32'd9; req_b3 = 32'd9; req_valid3 = 1'b1; rsp_ready3 = 1'b1;
    tick();
    req_valid3 = 1'b0;
    cyc = 0; en = 0;
    while (!rsp_valid3 && cyc < 20) begin
      if (mul_en3) en++;
      tick();
      cyc++;
    end
    chk("lat3 latency", 32'(cyc), 32'd4);
    chk("lat3 mul_en cycles", 32'(en), 32'd3);
    chk("lat3 result", rsp_result3, 32'h51);
    tick();
    chk("lat3 idle", {30'd0, busy3, rsp_valid3}, 32'd0);

    // Asynchronous reset mid-ISSUE.
    req_a3 = 32'd9; req_b3 = 32'd9; req_valid3 = 1'b1;
    tick();
    req_valid3 = 1'b0;
    tick();
    chk("lat3 in ISSUE", 32'(mul_en3), 32'd1);
    #2;
    rst3_n = 1'b0;
    #1;
    chk("async reset ctrl", {29'd0, busy3, rsp_valid3, mul_en3}, 32'd0);
    chk("async reset src1", src1_3, 32'd0);
    chk("async reset src2", src2_3, 32'd0);
    chk("async reset result", rsp_result3, 32'd0);
    @(posedge clk);
    #1;
    rst3_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid3 || busy3) seen = 1'b1;
      tick();
    end
    chk("async reset no response", 32'(seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_mul_seq_ctrl.md
Name: cpu_mul_seq_ctrl

Overview:
- Sequencing and combine stage that wraps the CPU's three-product 16x16 multiplier cell.
- Accepts 32x32 multiply requests over a valid/ready handshake and drives operands and enable to the cell.
- Waits out the cell's registered latency, then sums the three partial products into the low 32 bits of the product.
- Returns the result over a valid/ready response handshake. Sits between the execute-stage operand bus and the cell's p1/p2/p3 outputs.

Parameters:
- CELL_LATENCY, 1, clock-enabled cycles from operands stable to p1..p3 valid (range 1..7).

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous abort of any in-flight operation
- req_valid  input  1  request present
- req_ready  output  1  request accepted when high with req_valid
- req_a  input  32  multiplicand
- req_b  input  32  multiplier
- mul_src1  output  32  operand A to cell (registered)
- mul_src2  output  32  operand B to cell (registered)
- mul_en  output  1  cell clock enable
- cell_p1  input  32  A[15:0]*B[15:0]
- cell_p2  input  32  A[15:0]*B[31:16]
- cell_p3  input  32  A[31:16]*B[15:0]
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer accepts result
- rsp_result  output  32  low 32 bits of A*B
- busy  output  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low on reset_n.
- Reset values:
  - state=IDLE.
  - mul_src1, mul_src2, rsp_result, mul_en, rsp_valid, busy all 0.
  - Latency counter 0.
  - req_ready=1 once reset_n is high.
- States:
  - IDLE:
    - req_ready=1.
    - On req_valid: load mul_src1<=req_a, mul_src2<=req_b, counter<=CELL_LATENCY-1, go to ISSUE.
  - ISSUE:
    - mul_en=1 (combinational from state).
    - If counter==0, go to COMBINE; else decrement.
    - mul_src1/2 are held constant throughout.
  - COMBINE:
    - mul_en=0, so the cell holds its outputs.
    - rsp_result <= cell_p1 + {(cell_p2 + cell_p3)[15:0], 16'h0000}, modulo 2^32.
    - Upper bits of the partials and all carries beyond bit 31 are discarded.
    - rsp_valid<=1, go to RESP.
  - RESP:
    - rsp_valid=1; rsp_result stable until the handshake.
    - On rsp_ready: rsp_valid<=0.
    - If req_valid is also high in the same cycle, accept the new request (load operands, go to ISSUE). Otherwise go to IDLE.
- req_ready = (state==IDLE) | (state==RESP & rsp_ready). This is combinational and documented as a rsp_ready->req_ready path.
- Latency:
  - Accept edge E0.
  - rsp_valid is high after edge E0+CELL_LATENCY+1.
  - CELL_LATENCY=1: 2 cycles from accept to rsp_valid.
  - Back-to-back throughput: one result per CELL_LATENCY+2 cycles.
- busy=1 in ISSUE, COMBINE and RESP.
- flush:
  - Highest priority, any state.
  - Next state is IDLE; rsp_valid, mul_en and counter are cleared.
  - mul_src1/2 and rsp_result are left unchanged.
  - A request presented in the same cycle as flush is NOT accepted; req_ready is forced 0 while flush=1.
- Reset asserted mid-operation: immediate return to reset values. No response is produced for the lost request.
- Signedness: the low 32 bits are identical for signed and unsigned operands, so there is no sign mode.
- rsp_valid must never drop without a rsp_ready handshake, except on flush or reset.

Test Plan:
- Reset, then req_a=0x00010003, req_b=0x00000005, rsp_ready=1 → cell sees mul_en=1 for exactly 1 cycle; rsp_result=0x0005000F with rsp_valid high 2 cycles after accept.
- req_a=req_b=0xFFFFFFFF (p1=p2=p3=0xFFFE0001) → rsp_result=0x00000001, proving truncation of the cross-term carry and the final sum.
- req_a=req_b=0x00010000 → rsp_result=0x00000000; then 0x00000003*0x00000007 with rsp_ready held low for 5 cycles → rsp_valid and rsp_result=0x00000015 stay stable, and req_ready=0 throughout.
- Two queued requests (2*3, 4*5), rsp_ready=1, req_valid continuous → second accepted on the same edge as the first response handshake; results 0x6 then 0x14, 3 cycles apart (CELL_LATENCY=1).
- flush asserted in ISSUE, with req_valid high during the flush cycle → no response; busy=0 next cycle; the concurrent request is not accepted; a following 0x10*0x10 returns 0x100.
- CELL_LATENCY=3: 9*9 → mul_en high exactly 3 consecutive cycles; rsp_result=0x51. Then reset_n pulsed low mid-ISSUE → all outputs 0 asynchronously, no response.
